// File: rtl/ccip_ring_writer_pkg.sv
// Shared NIC definitions for the ring writer: CCI-P channel-1 write types,
// the RPC packet layout and the ring-writer FSM encoding.
package ccip_ring_writer_pkg;

    localparam int CCIP_CLADDR_WIDTH = 42;
    localparam int CCIP_CLDATA_WIDTH = 512;
    localparam int CCIP_MDATA_WIDTH  = 16;

    typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
    typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;
    typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic       valid;
        logic       update_flag;
        logic [5:0] rsvd;
    } RpcCtl;

    typedef struct packed {
        RpcCtl       ctl;
        logic [7:0]  n_args;
        logic [31:0] rpc_id;
    } RpcHdr;

    typedef struct packed {
        RpcHdr        hdr;
        logic [127:0] argv;
    } RpcPckt;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN
    } t_ring_state;

    // The poller keys on update_flag, so every line must carry the ring's lap.
    function automatic RpcPckt stamp_ctl(input RpcPckt p, input logic lap);
        RpcPckt r;
        r = p;
        r.hdr.ctl.valid       = 1'b1;
        r.hdr.ctl.update_flag = lap;
        return r;
    endfunction

endpackage

// File: rtl/ccip_ring_writer_ram.sv
// Per-flow tail table: simple dual-port RAM, registered read,
// read-during-write returns the old contents.
module single_clock_wr_ram #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        q <= mem[raddr];
    end

endmodule

// File: rtl/ccip_ring_writer.sv
// Writes accepted RPCs into per-flow CPU ring buffers over CCI-P channel 1.
// Optional CCIP_RING_WRITER_STATS_EN adds write/wrap counters on debug_out.
module ccip_ring_writer
    import ccip_ring_writer_pkg::*;
#(
    parameter int NIC_ID             = 0,
    parameter int LMAX_NUM_OF_FLOWS  = 1,
    parameter int LMAX_TX_QUEUE_SIZE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
    input  t_ccip_clAddr                  rx_base_addr,
    input  logic [LMAX_TX_QUEUE_SIZE:0]   tx_queue_size,
    input  logic                          start,
    input  logic                          initialize,
    output logic                          initialized,
    output logic                          error,
    input  logic                          sRx_c1TxAlmFull,
    output t_if_ccip_c1_Tx                sTx_c1,
    output logic                          ccip_tx_ready,
    input  RpcPckt                        rpc_in,
    input  logic                          rpc_in_valid,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]  rpc_flow_id_in,
    output logic [31:0]                   pdrop_out,
    output logic [63:0]                   debug_out
);

    localparam int LF = LMAX_NUM_OF_FLOWS;
    localparam int LQ = LMAX_TX_QUEUE_SIZE;
    localparam logic [LQ:0] QONE = (LQ+1)'(1);

    t_ring_state        state;
    logic [LF-1:0]      init_addr;
    logic               accept, bad_flow, drop;

    logic               s1_vld, s1_fwd;
    logic [LF-1:0]      s1_flow;
    RpcPckt             s1_rpc;
    logic [LQ:0]        s1_fwd_ent;

    logic [LQ:0]        rd_ent, cur_ent, nxt_ent;
    logic [LQ-1:0]      slot;
    logic               lap, wrap;

    logic               tbl_we;
    logic [LF-1:0]      tbl_waddr;
    logic [LQ:0]        tbl_wdata;
    t_ccip_c1_ReqMemHdr tx_hdr;

    assign ccip_tx_ready = (state == ST_RUN) && start && !sRx_c1TxAlmFull;
    assign bad_flow      = rpc_in_valid && (rpc_flow_id_in > number_of_flows);
    assign accept        = rpc_in_valid && ccip_tx_ready && !bad_flow;
    assign drop          = rpc_in_valid && !accept;

    // RAM returns stale data when the previous RPC hit the same flow.
    assign cur_ent = s1_fwd ? s1_fwd_ent : rd_ent;
    assign slot    = cur_ent[LQ-1:0];
    assign lap     = cur_ent[LQ];
    assign wrap    = ({1'b0, slot} == (tx_queue_size - QONE));
    assign nxt_ent = wrap ? {~lap, {LQ{1'b0}}} : {lap, slot + LQ'(1)};

    assign tbl_we    = (state == ST_INIT) || s1_vld;
    assign tbl_waddr = (state == ST_INIT) ? init_addr : s1_flow;
    assign tbl_wdata = (state == ST_INIT) ? {1'b1, {LQ{1'b0}}} : nxt_ent;

    single_clock_wr_ram #(
        .DATA_WIDTH (LQ+1),
        .ADDR_WIDTH (LF)
    ) u_flow_tbl (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
        .raddr (rpc_flow_id_in),
        .q     (rd_ent)
    );

    // {flow, slot} equals (flow << LQ) + slot since slot < 2^LQ.
    always_comb begin
        tx_hdr          = '0;
        tx_hdr.vc_sel   = eVC_VH0;
        tx_hdr.sop      = 1'b1;
        tx_hdr.cl_len   = eCL_LEN_1;
        tx_hdr.req_type = eREQ_WRLINE_I;
        tx_hdr.address  = rx_base_addr + t_ccip_clAddr'({s1_flow, slot});
        tx_hdr.mdata    = t_ccip_mdata'({s1_flow, slot});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            init_addr   <= '0;
            initialized <= 1'b0;
            error       <= 1'b0;
            pdrop_out   <= '0;
            s1_vld      <= 1'b0;
            s1_fwd      <= 1'b0;
            sTx_c1      <= '0;
        end else begin
            case (state)
                ST_IDLE: if (initialize && !initialized) begin
                    state     <= ST_INIT;
                    init_addr <= '0;
                end
                ST_INIT: begin
                    init_addr <= init_addr + LF'(1);
                    if (&init_addr) begin
                        state       <= ST_RUN;
                        initialized <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (bad_flow)
                error <= 1'b1;
            if (drop && pdrop_out != '1)
                pdrop_out <= pdrop_out + 32'd1;

            s1_vld <= accept;
            if (accept) begin
                s1_flow    <= rpc_flow_id_in;
                s1_rpc     <= rpc_in;
                s1_fwd     <= s1_vld && (s1_flow == rpc_flow_id_in);
                s1_fwd_ent <= nxt_ent;
            end

            sTx_c1.valid <= s1_vld;
            if (s1_vld) begin
                sTx_c1.hdr  <= tx_hdr;
                sTx_c1.data <= t_ccip_clData'(stamp_ctl(s1_rpc, lap));
            end
        end
    end

`ifdef CCIP_RING_WRITER_STATS_EN
    logic [31:0] wr_cnt, wrap_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt   <= '0;
            wrap_cnt <= '0;
        end else if (s1_vld) begin
            wr_cnt <= wr_cnt + 32'd1;
            if (wrap)
                wrap_cnt <= wrap_cnt + 32'd1;
            $display("ring_writer nic %0d: write flow %0d slot %0d", NIC_ID, s1_flow, slot);
        end
    end

    assign debug_out = {wrap_cnt, wr_cnt};
`else
    assign debug_out = '0;
`endif

endmodule
